// File: rtl/mclk_pause_ctrl.sv
// Pause/resume/single-step controller producing the registered mclk_pause level for the mclk gate.
// Optional enabled-cycle counter (cnt_clr / mclk_cycles) is built when MCLK_CYCLE_CNT_EN is defined.
module mclk_pause_ctrl #(
  parameter int STEP_W       = 16,
  parameter bit RESET_PAUSED = 1'b1
`ifdef MCLK_CYCLE_CNT_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              pause_req,
  input  logic              resume_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_n,
  input  logic              hold,
`ifdef MCLK_CYCLE_CNT_EN
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  mclk_cycles,
`endif
  output logic              mclk_pause,
  output logic              paused,
  output logic              busy,
  output logic [STEP_W-1:0] steps_left
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_PAUSED = 2'd1,
    S_STEP   = 2'd2
  } state_t;

  localparam state_t RESET_STATE = RESET_PAUSED ? S_PAUSED : S_RUN;

  state_t            state;
  state_t            next_state;
  logic [STEP_W-1:0] next_left;

  // Requests are single-cycle pulses; priority is pause > step > resume.
  always_comb begin
    next_state = state;
    next_left  = steps_left;
    case (state)
      S_RUN: begin
        if (pause_req) begin
          next_state = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause_req) begin
          next_state = S_PAUSED;
        end else if (step_req && (step_n != '0)) begin
          next_state = S_STEP;
          next_left  = step_n;
        end else if (resume_req) begin
          next_state = S_RUN;
        end
      end
      S_STEP: begin
        if (pause_req) begin
          next_state = S_PAUSED;
          next_left  = '0;
        end else if (resume_req) begin
          next_state = S_RUN;
          next_left  = '0;
        end else if (!mclk_pause) begin
          // Only enabled cycles consume step budget; hold freezes the count.
          if (steps_left == STEP_W'(1)) begin
            next_state = S_PAUSED;
            next_left  = '0;
          end else begin
            next_left = steps_left - STEP_W'(1);
          end
        end
      end
      default: begin
        next_state = S_PAUSED;
        next_left  = '0;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_STATE;
      steps_left <= '0;
      mclk_pause <= RESET_PAUSED;
      paused     <= RESET_PAUSED;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      steps_left <= next_left;
      mclk_pause <= hold | (next_state == S_PAUSED);
      paused     <= (next_state == S_PAUSED);
      busy       <= (next_state == S_STEP);
    end
  end

`ifdef MCLK_CYCLE_CNT_EN
  // Counts enabled mclk cycles, wrapping naturally; clear beats increment.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      mclk_cycles <= '0;
    end else if (cnt_clr) begin
      mclk_cycles <= '0;
    end else if (!mclk_pause) begin
      mclk_cycles <= mclk_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mclk_pause_ctrl.sv
// Bench for mclk_pause_ctrl: vector table plus hand sequences for abort, async reset and the
// optional MCLK_CYCLE_CNT_EN counter, all checked through an expected-value queue.
module tb_mclk_pause_ctrl;

  localparam int STEP_W = 16;
  localparam int EXP_W  = STEP_W + 3;

  logic              sclk;
  logic              rst_n;
  logic              pause_req;
  logic              resume_req;
  logic              step_req;
  logic [STEP_W-1:0] step_n;
  logic              hold;
  logic              mclk_pause;
  logic              paused;
  logic              busy;
  logic [STEP_W-1:0] steps_left;
`ifdef MCLK_CYCLE_CNT_EN
  logic              cnt_clr;
  logic [31:0]       mclk_cycles;
`endif

  mclk_pause_ctrl #(
    .STEP_W       (STEP_W),
    .RESET_PAUSED (1'b1)
  ) dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .pause_req   (pause_req),
    .resume_req  (resume_req),
    .step_req    (step_req),
    .step_n      (step_n),
    .hold        (hold),
`ifdef MCLK_CYCLE_CNT_EN
    .cnt_clr     (cnt_clr),
    .mclk_cycles (mclk_cycles),
`endif
    .mclk_pause  (mclk_pause),
    .paused      (paused),
    .busy        (busy),
    .steps_left  (steps_left)
  );

  // clock / reset
  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  typedef struct {
    logic              pause;
    logic              resume;
    logic              step;
    logic [STEP_W-1:0] n;
    logic              hold;
    logic              mp;
    logic              p;
    logic              b;
    logic [STEP_W-1:0] sl;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

  logic [EXP_W-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input logic pr, input logic rr, input logic sr,
                              input logic [STEP_W-1:0] n, input logic h,
                              input logic mp, input logic p, input logic b,
                              input logic [STEP_W-1:0] sl);
    vec_t v;
    v.pause = pr; v.resume = rr; v.step = sr; v.n = n; v.hold = h;
    v.mp = mp; v.p = p; v.b = b; v.sl = sl;
    return v;
  endfunction

  // scoreboard: pop the oldest expectation and compare to the live outputs
  task automatic score(input string nm);
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] e;
    got = {mclk_pause, paused, busy, steps_left};
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty got=%h", nm, got);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s got={mp,p,b,sl}=%h exp=%h", nm, got, e);
      end
    end
  endtask

  // driver: inputs change at negedge, outputs sampled 1 time unit after the posedge
  task automatic apply(input vec_t v, input string nm);
    @(negedge sclk);
    pause_req  = v.pause;
    resume_req = v.resume;
    step_req   = v.step;
    step_n     = v.n;
    hold       = v.hold;
    exp_q.push_back({v.mp, v.p, v.b, v.sl});
    @(posedge sclk);
    #1;
    score(nm);
  endtask

  task automatic idle(input logic mp, input logic p, input logic b,
                      input logic [STEP_W-1:0] sl, input string nm);
    apply(mk(0, 0, 0, '0, 0, mp, p, b, sl), nm);
  endtask

  initial begin
    int k;
    // main sequence: tests 1..4 and assorted ignore/priority cases
    vecs[0]  = mk(0, 1, 0, 16'd0,   0, 0, 0, 0, 16'd0);  // resume -> RUN
    vecs[1]  = mk(0, 0, 0, 16'd0,   0, 0, 0, 0, 16'd0);
    vecs[2]  = mk(1, 0, 0, 16'd0,   0, 1, 1, 0, 16'd0);  // pause
    vecs[3]  = mk(0, 0, 1, 16'd5,   0, 0, 0, 1, 16'd5);  // step 5
    vecs[4]  = mk(0, 0, 0, 16'd0,   0, 0, 0, 1, 16'd4);
    vecs[5]  = mk(0, 0, 0, 16'd0,   0, 0, 0, 1, 16'd3);
    vecs[6]  = mk(0, 0, 0, 16'd0,   0, 0, 0, 1, 16'd2);
    vecs[7]  = mk(0, 0, 0, 16'd0,   0, 0, 0, 1, 16'd1);
    vecs[8]  = mk(0, 0, 0, 16'd0,   0, 1, 1, 0, 16'd0);  // 5 enabled cycles done
    vecs[9]  = mk(0, 0, 0, 16'd0,   0, 1, 1, 0, 16'd0);
    vecs[10] = mk(0, 0, 1, 16'd4,   0, 0, 0, 1, 16'd4);  // step 4 with hold
    vecs[11] = mk(0, 0, 0, 16'd0,   0, 0, 0, 1, 16'd3);
    vecs[12] = mk(0, 0, 0, 16'd0,   1, 1, 0, 1, 16'd2);
    vecs[13] = mk(0, 0, 0, 16'd0,   1, 1, 0, 1, 16'd2);
    vecs[14] = mk(0, 0, 0, 16'd0,   1, 1, 0, 1, 16'd2);
    vecs[15] = mk(0, 0, 0, 16'd0,   0, 0, 0, 1, 16'd2);
    vecs[16] = mk(0, 0, 0, 16'd0,   0, 0, 0, 1, 16'd1);
    vecs[17] = mk(0, 0, 0, 16'd0,   0, 1, 1, 0, 16'd0);
    vecs[18] = mk(0, 0, 1, 16'd0,   0, 1, 1, 0, 16'd0);  // step_n=0 ignored
    vecs[19] = mk(0, 1, 0, 16'd0,   0, 0, 0, 0, 16'd0);  // resume
    vecs[20] = mk(1, 1, 0, 16'd0,   0, 1, 1, 0, 16'd0);  // pause beats resume
    vecs[21] = mk(0, 1, 1, 16'd3,   0, 0, 0, 1, 16'd3);  // step beats resume
    vecs[22] = mk(0, 0, 1, 16'd9,   0, 0, 0, 1, 16'd2);  // step ignored in STEP
    vecs[23] = mk(0, 1, 0, 16'd0,   0, 0, 0, 0, 16'd0);  // resume converts step
    vecs[24] = mk(0, 0, 1, 16'd7,   0, 0, 0, 0, 16'd0);  // step ignored in RUN
    vecs[25] = mk(0, 0, 0, 16'd0,   1, 1, 0, 0, 16'd0);  // hold in RUN
    vecs[26] = mk(0, 0, 0, 16'd0,   0, 0, 0, 0, 16'd0);  // hold released
    vecs[27] = mk(1, 0, 0, 16'd0,   0, 1, 1, 0, 16'd0);
    vecs[28] = mk(0, 0, 0, 16'd0,   1, 1, 1, 0, 16'd0);  // hold in PAUSED
    vecs[29] = mk(0, 0, 0, 16'd0,   0, 1, 1, 0, 16'd0);
    vecs[30] = mk(1, 0, 1, 16'd6,   0, 1, 1, 0, 16'd0);  // pause beats step

    rst_n = 1'b0;
    pause_req = 1'b0; resume_req = 1'b0; step_req = 1'b0; step_n = '0; hold = 1'b0;
`ifdef MCLK_CYCLE_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge sclk);
    #1;
    exp_q.push_back({1'b1, 1'b1, 1'b0, 16'd0});
    score("reset");
    @(negedge sclk);
    rst_n = 1'b1;
    idle(1, 1, 0, 16'd0, "post_reset");

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // step 100, abort with pause after a random number of enabled cycles
    k = $urandom_range(20, 5);
    apply(mk(0, 0, 1, 16'd100, 0, 0, 0, 1, 16'd100), "abort_step");
    for (int i = 1; i < k; i++) begin
      idle(0, 0, 1, STEP_W'(100 - i), $sformatf("abort_run%0d", i));
    end
    apply(mk(1, 0, 0, 16'd0, 0, 1, 1, 0, 16'd0), "abort_pause");
    idle(1, 1, 0, 16'd0, "abort_stays");

    // same again, but async reset lands mid-step between edges
    apply(mk(0, 0, 1, 16'd100, 0, 0, 0, 1, 16'd100), "rst_step");
    for (int i = 1; i <= 10; i++) begin
      idle(0, 0, 1, STEP_W'(100 - i), $sformatf("rst_run%0d", i));
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back({1'b1, 1'b1, 1'b0, 16'd0});
    score("async_reset");
    @(negedge sclk);
    rst_n = 1'b1;
    idle(1, 1, 0, 16'd0, "after_reset");

`ifdef MCLK_CYCLE_CNT_EN
    // counter: clear, then a 5-cycle step must add exactly 5
    @(negedge sclk);
    cnt_clr = 1'b1;
    @(posedge sclk);
    #1;
    total++;
    if (mclk_cycles !== 32'd0) begin
      bad++;
      $display("FAIL cnt_clr got=%0d exp=0", mclk_cycles);
    end
    @(negedge sclk);
    cnt_clr = 1'b0;
    apply(mk(0, 0, 1, 16'd5, 0, 0, 0, 1, 16'd5), "cnt_step");
    for (int i = 1; i < 5; i++) begin
      idle(0, 0, 1, STEP_W'(5 - i), $sformatf("cnt_run%0d", i));
    end
    idle(1, 1, 0, 16'd0, "cnt_done");
    total++;
    if (mclk_cycles !== 32'd5) begin
      bad++;
      $display("FAIL cnt_step5 got=%0d exp=5", mclk_cycles);
    end
`endif

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover expectations got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
